// File: rtl/snake_gfx_pkg.sv
// Shared types and constants for the snake-head sprite datapath.
//   dir_t           : head direction encoding (matches the dir_in port coding)
//   rgb12_t         : 4:4:4 colour triple
//   TRANSPARENT_IDX : palette index that lets the background show through
package snake_gfx_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam int SPRITE_W_DEF = 16;
  localparam int SPRITE_H_DEF = 16;

  localparam logic [3:0] TRANSPARENT_IDX = 4'd0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

endpackage

// File: rtl/snake_sprite_ctrl_if.sv
// Bus between the sprite controller and the external sprite ROMs / palettes.
//   rom_addr   : address presented to every sprite ROM (registered)
//   sprite_sel : {dir, frame}, picks which ROM output / palette is returned
//   pal_index  : selected ROM output, one cycle after rom_addr
//   pal_*      : palette colour for pal_index, combinational
// master = controller side, slave = ROM/palette side.
interface snake_sprite_if #(
  parameter int ROM_AW = 8
);

  logic [ROM_AW-1:0] rom_addr;
  logic [2:0]        sprite_sel;
  logic [3:0]        pal_index;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;

  modport master (
    output rom_addr, sprite_sel,
    input  pal_index, pal_red, pal_green, pal_blue
  );

  modport slave (
    input  rom_addr, sprite_sel,
    output pal_index, pal_red, pal_green, pal_blue
  );

endinterface

// File: rtl/snake_sprite_ctrl_anim_sched.sv
// Animation scheduler: counts frame_start pulses, toggles the animation
// frame every ANIM_DIV pulses and latches the head direction once per frame.
//   Clk, Reset  : clock, synchronous active-high reset
//   frame_start : one-cycle pulse at start of vertical blank
//   pause       : holds the counter and frame bit (direction still latches)
//   dir_in      : requested direction
//   sprite_sel  : {dir_q, anim_frame}
//   anim_frame  : current animation frame bit
module anim_sched
  import snake_gfx_pkg::*;
#(
  parameter int ANIM_DIV = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       pause,
  input  dir_t       dir_in,
  output logic [2:0] sprite_sel,
  output logic       anim_frame
);

  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);

  logic [CNT_W-1:0] frame_cnt;
  dir_t             dir_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_cnt  <= '0;
      anim_frame <= 1'b0;
      dir_q      <= DOWN;
    end else if (frame_start) begin
      // Direction updates only here so the sprite never changes mid-frame.
      dir_q <= dir_in;
      if (!pause) begin
        if (frame_cnt == CNT_LAST) begin
          frame_cnt  <= '0;
          anim_frame <= ~anim_frame;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign sprite_sel = {dir_q, anim_frame};

endmodule

// File: rtl/snake_sprite_ctrl.sv
// Snake-head sprite compositor. Hit-tests each pixel against the sprite box,
// addresses the sprite ROM, and overlays the palette colour on the
// background. Three register stages: address, ROM read, output colour.
//   Clk, Reset            : clock, synchronous active-high reset
//   frame_start, pause    : animation control
//   dir_in                : requested head direction
//   head_x, head_y        : sprite top-left
//   DrawX, DrawY, blank   : VGA pixel position, blank=1 means active video
//   bg_red/green/blue     : background colour for this pixel
//   rom                   : ROM/palette bus (master side)
//   red, green, blue      : registered output colour
module snake_sprite_ctrl
  import snake_gfx_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF,
  parameter int ANIM_DIV = 8,
  parameter int ROM_AW   = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        pause,
  input  logic [1:0]  dir_in,
  input  logic [9:0]  head_x,
  input  logic [9:0]  head_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic [3:0]  bg_red,
  input  logic [3:0]  bg_green,
  input  logic [3:0]  bg_blue,
  snake_sprite_if.master rom,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);

  logic anim_frame;

  anim_sched #(.ANIM_DIV(ANIM_DIV)) u_anim_sched (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pause       (pause),
    .dir_in      (dir_t'(dir_in)),
    .sprite_sel  (rom.sprite_sel),
    .anim_frame  (anim_frame)
  );

  // Stage 0: hit test in 11 bits so head_x + SPRITE_W past 1023 cannot wrap.
  logic [10:0]       x11, y11, hx11, hy11;
  logic              hit;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ROM_AW-1:0] addr_d;

  always_comb begin
    x11  = {1'b0, DrawX};
    y11  = {1'b0, DrawY};
    hx11 = {1'b0, head_x};
    hy11 = {1'b0, head_y};
    hit  = (x11 >= hx11) && (x11 < hx11 + 11'(SPRITE_W)) &&
           (y11 >= hy11) && (y11 < hy11 + 11'(SPRITE_H));
    // Only the low bits matter; the difference modulo sprite size is exact.
    col    = DrawX[COL_W-1:0] - head_x[COL_W-1:0];
    row    = DrawY[ROW_W-1:0] - head_y[ROW_W-1:0];
    addr_d = hit ? ROM_AW'({row, col}) : '0;
  end

  // Stage 1 and 2: address out, sideband delayed to meet the ROM read data.
  logic   hit_q1, blank_q1, hit_q2, blank_q2;
  rgb12_t bg_q1, bg_q2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom.rom_addr <= '0;
      hit_q1       <= 1'b0;
      blank_q1     <= 1'b0;
      bg_q1        <= '0;
      hit_q2       <= 1'b0;
      blank_q2     <= 1'b0;
      bg_q2        <= '0;
    end else begin
      rom.rom_addr <= addr_d;
      hit_q1       <= hit;
      blank_q1     <= blank;
      bg_q1        <= '{r: bg_red, g: bg_green, b: bg_blue};
      hit_q2       <= hit_q1;
      blank_q2     <= blank_q1;
      bg_q2        <= bg_q1;
    end
  end

  // Stage 3: composite. Zeroed blank regs after reset force black until
  // fresh pixels reach this stage, so no partial sprite colour leaks out.
  rgb12_t pix_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_q <= '0;
    end else if (!blank_q2) begin
      pix_q <= '0;
    end else if (hit_q2 && (rom.pal_index != TRANSPARENT_IDX)) begin
      pix_q <= '{r: rom.pal_red, g: rom.pal_green, b: rom.pal_blue};
    end else begin
      pix_q <= bg_q2;
    end
  end

  assign red   = pix_q.r;
  assign green = pix_q.g;
  assign blue  = pix_q.b;

  // anim_frame is also carried in sprite_sel; kept as a named probe point.
  logic unused_ok;
  assign unused_ok = anim_frame;

endmodule

// File: tb/tb_snake_sprite_ctrl.sv
module tb_snake_sprite_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_start;
  logic       pause;
  logic [1:0] dir_in;
  logic [9:0] head_x, head_y, DrawX, DrawY;
  logic       blank;
  logic [3:0] bg_red, bg_green, bg_blue;
  logic [3:0] red, green, blue;

  int total = 0;
  int bad   = 0;

  snake_sprite_if #(.ROM_AW(8)) rom_bus ();

  snake_sprite_ctrl #(
    .SPRITE_W(16), .SPRITE_H(16), .ANIM_DIV(8), .ROM_AW(8)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pause       (pause),
    .dir_in      (dir_in),
    .head_x      (head_x),
    .head_y      (head_y),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .bg_red      (bg_red),
    .bg_green    (bg_green),
    .bg_blue     (bg_blue),
    .rom         (rom_bus.master),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  // Clock / reset block
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  // One pixel through the pipeline; pal_index is supplied after the address
  // edge, as a registered ROM would.
  task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic b, input logic [11:0] bg, input logic [3:0] idx,
                       input logic [11:0] pal, input logic [7:0] exp_addr,
                       input logic [11:0] exp_rgb);
    DrawX = x;
    DrawY = y;
    blank = b;
    {bg_red, bg_green, bg_blue} = bg;
    tick();
    check({tag, "_addr"}, 16'(rom_bus.rom_addr), 16'(exp_addr));
    tick();
    rom_bus.pal_index = idx;
    {rom_bus.pal_red, rom_bus.pal_green, rom_bus.pal_blue} = pal;
    tick();
    check({tag, "_rgb"}, 16'({red, green, blue}), 16'(exp_rgb));
  endtask

  initial begin
    Reset = 1'b1;
    frame_start = 1'b0;
    pause = 1'b0;
    dir_in = 2'd0;
    head_x = 10'd100;
    head_y = 10'd50;
    DrawX = 10'd0;
    DrawY = 10'd0;
    blank = 1'b1;
    {bg_red, bg_green, bg_blue} = 12'h000;
    rom_bus.pal_index = 4'd0;
    {rom_bus.pal_red, rom_bus.pal_green, rom_bus.pal_blue} = 12'h000;
    tick();
    tick();
    check("rst_sel", 16'(rom_bus.sprite_sel), 16'h2);
    check("rst_addr", 16'(rom_bus.rom_addr), 16'h0);
    check("rst_rgb", 16'({red, green, blue}), 16'h0);
    Reset = 1'b0;

    // Direction latch and animation counter
    dir_in = 2'd2;
    pulse(1);
    check("sel_left", 16'(rom_bus.sprite_sel), 16'h4);
    pulse(2);
    check("sel_after3", 16'(rom_bus.sprite_sel), 16'h4);
    pulse(4);
    check("sel_after7", 16'(rom_bus.sprite_sel), 16'h4);
    pulse(1);
    check("sel_toggle8", 16'(rom_bus.sprite_sel), 16'h5);
    pause = 1'b1;
    dir_in = 2'd3;
    pulse(8);
    check("sel_paused", 16'(rom_bus.sprite_sel), 16'h7);
    pause = 1'b0;
    pulse(7);
    check("sel_resume7", 16'(rom_bus.sprite_sel), 16'h7);
    pulse(1);
    check("sel_resume8", 16'(rom_bus.sprite_sel), 16'h6);

    // Pixel pipeline, head at (100,50)
    pixel("hit_pal",     10'd105, 10'd53, 1'b1, 12'h123, 4'd7, 12'hA86, 8'h35, 12'hA86);
    pixel("hit_transp",  10'd105, 10'd53, 1'b1, 12'h123, 4'd0, 12'hA86, 8'h35, 12'h123);
    pixel("miss_right",  10'd116, 10'd53, 1'b1, 12'h123, 4'd7, 12'hA86, 8'h00, 12'h123);
    pixel("edge_right",  10'd115, 10'd53, 1'b1, 12'h456, 4'd3, 12'h9C1, 8'h3F, 12'h9C1);
    pixel("miss_left",   10'd99,  10'd53, 1'b1, 12'h456, 4'd3, 12'h9C1, 8'h00, 12'h456);
    pixel("edge_bottom", 10'd105, 10'd65, 1'b1, 12'h456, 4'd5, 12'h2B7, 8'hF5, 12'h2B7);
    pixel("miss_below",  10'd105, 10'd66, 1'b1, 12'h789, 4'd5, 12'h2B7, 8'h00, 12'h789);
    pixel("blanked",     10'd105, 10'd53, 1'b0, 12'h123, 4'd7, 12'hA86, 8'h35, 12'h000);

    // Sprite hanging off the right edge
    head_x = 10'd630;
    pixel("offscr_hit",  10'd639, 10'd53, 1'b1, 12'h321, 4'd7, 12'hA86, 8'h39, 12'hA86);
    pixel("offscr_nowr", 10'd4,   10'd53, 1'b1, 12'h321, 4'd7, 12'hA86, 8'h00, 12'h321);

    // Reset mid-line while on a sprite pixel
    head_x = 10'd100;
    DrawX = 10'd105;
    DrawY = 10'd53;
    blank = 1'b1;
    {bg_red, bg_green, bg_blue} = 12'h123;
    rom_bus.pal_index = 4'd7;
    {rom_bus.pal_red, rom_bus.pal_green, rom_bus.pal_blue} = 12'hA86;
    tick();
    tick();
    tick();
    check("pre_rst_rgb", 16'({red, green, blue}), 16'hA86);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_sel", 16'(rom_bus.sprite_sel), 16'h2);
    check("mid_rst_rgb0", 16'({red, green, blue}), 16'h0);
    tick();
    check("mid_rst_rgb1", 16'({red, green, blue}), 16'h0);
    tick();
    check("mid_rst_rgb2", 16'({red, green, blue}), 16'h0);
    tick();
    check("mid_rst_resume", 16'({red, green, blue}), 16'hA86);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snake_sprite_ctrl.md
# snake_sprite_ctrl

Sequences the snake-head sprite ROMs and their 16-entry colour palettes for the VGA pixel stream. Each animation frame it selects one of eight sprite/palette pairs (4 directions × 2 frames), generates the ROM address for the current pixel, and composites the palette colour over the background layer. Sits between the VGA controller / background renderer and the final RGB output register.

## Interface

Parameters:
- SPRITE_W, 16: sprite width in pixels (power of 2).
- SPRITE_H, 16: sprite height in pixels (power of 2).
- ANIM_DIV, 8: number of frame_start pulses per animation-frame toggle (≥1).
- ROM_AW, 8: sprite ROM address width, equal to log2(SPRITE_W·SPRITE_H).

Ports (one clock; reset is synchronous and active-high):
- Clk  in  1  system pixel clock.
- Reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- pause  in  1  freezes the animation counter.
- dir_in  in  2  requested head direction: 0 up, 1 down, 2 left, 3 right.
- head_x, head_y  in  10  sprite top-left pixel position.
- DrawX, DrawY  in  10  current pixel coordinate from the VGA controller.
- blank  in  1  1 = active video, 0 = blanking.
- bg_red, bg_green, bg_blue  in  4 each  background colour for DrawX/DrawY this cycle.
- rom_addr  out  ROM_AW  registered address to all sprite ROMs.
- sprite_sel  out  3  {dir, frame}: selects ROM output and palette.
- pal_index  in  4  selected ROM output (1-cycle registered read).
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index (combinational).
- red, green, blue  out  4 each  registered final pixel colour.

## Operation

- Animation scheduler: frame_cnt counts frame_start pulses modulo ANIM_DIV; on wrap (cnt = ANIM_DIV−1 and pulse) anim_frame toggles. pause=1 holds frame_cnt and anim_frame.
- dir_q latches dir_in only on frame_start (pause does not block it); sprite_sel = {dir_q, anim_frame} changes only on frame_start, never mid-frame.
- Hit test (stage 0, combinational): hit = DrawX ≥ head_x && DrawX < head_x+SPRITE_W && same for Y; compare in 11 bits so head_x near 639 does not wrap. col = DrawX−head_x, row = DrawY−head_y (low bits).
- Stage 1 registers: rom_addr = row·SPRITE_W + col (0 when no hit), hit_q1, blank_q1, bg_q1.
- Stage 2: ROM returns pal_index; hit_q2, blank_q2, bg_q2 aligned.
- Stage 3 output register: blank_q2=0 → 0; hit_q2=1 and pal_index≠TRANSPARENT_IDX → pal colour; else bg_q2.
- Reset: frame_cnt=0, anim_frame=0, dir_q=1 (down), sprite_sel=3'b010, rom_addr=0, all hit/blank pipeline regs=0, red/green/blue=0.

## Timing

- Latency: DrawX/DrawY/bg at cycle t → red/green/blue valid after the edge ending cycle t+2 (3 registers). Upstream shifts DrawX by 3 or accepts the offset.
- frame_start at edge e → sprite_sel new value visible after e; the first pixel using it is the first active pixel of the next frame.
- Simultaneous frame_start and dir_in change: the dir_in value sampled on that edge is latched.
- Simultaneous frame_start and pause=1: dir latches, counter holds.
- Reset mid-line: pipeline zeroed; outputs show 0 for 3 cycles, then resume normally. No partial sprite colour is output.
- Sprite partially off-screen (head_x > 640−SPRITE_W): visible columns draw; no wrap onto column 0.

## Structure

- Package snake_gfx_pkg: dir_t enum (UP, DOWN, LEFT, RIGHT), SPRITE_W/SPRITE_H defaults, TRANSPARENT_IDX = 4'd0, rgb12_t packed struct.
- Sub-module anim_sched: frame counter, anim_frame toggle, dir latch, sprite_sel output. Pixel pipeline stays in the top module.
- ROMs and palettes are instantiated outside. The top-level mux uses sprite_sel to pick pal_index and palette RGB.

## Test plan

- Reset, then drive 3 frame_start pulses with dir_in=2 → sprite_sel=3'b100 after the first pulse; anim_frame stays 0 (ANIM_DIV=8).
- Drive 8 frame_start pulses → anim_frame toggles exactly on the 8th; sprite_sel LSB goes 0→1. With pause=1, drive 8 more → unchanged.
- head=(100,50), DrawX=105, DrawY=53, pal_index=7, pal RGB=A86 → rom_addr=0x35 one cycle later; red/green/blue=A,8,6 three edges after the input.
- Same pixel with pal_index=0 and bg=123 → output 1,2,3. DrawX=116 (outside) → output bg and rom_addr=0.
- head_x=630, DrawX=639 → hit, col=9. DrawX=4 on the same row → no hit. blank=0 on any pixel → output 0.
- Assert Reset mid-line while hit → 3 cycles of 0 output, sprite_sel=3'b010, then correct colours resume.
